trace_scope: RTL and testbench

Parametrised logic-analyser block: captures `WIDTH`-bit samples into a `2**DEPTH_LOG2`-entry ring buffer around a trigger event, with a fixed pre-trigger window. Once the buffer is full it streams the window over a 8N1 UART, oldest sample first. It sits beside the design under debug and needs only one pin (`uart_tx`), replacing the fixed 64-bit, untriggered capture scope.

---
 rtl/trace_scope.sv | 204 ++++++++++++++++++++
 tb/tb_trace_scope.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/trace_scope.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : trace_scope
// Purpose  : Triggered ring-buffer logic analyser, window dumped over 8N1 UART
// Revision : 1.0
// ============================================================================
module trace_scope #(
    parameter int WIDTH      = 64,
    parameter int DEPTH_LOG2 = 14,
    parameter int PRETRIG    = 1024,
    parameter int CLKDIV     = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] trace_in,
    input  logic             trig_in,
    input  logic             arm,
    input  logic             abort,
    output logic             uart_tx,
    output logic             busy,
    output logic             triggered
);

    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int NBYTES = WIDTH / 8;
    localparam int BIDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int DIV_W  = $clog2(CLKDIV);

    localparam logic [DEPTH_LOG2:0]   PRE_FILL    = (DEPTH_LOG2+1)'(PRETRIG);
    localparam logic [DEPTH_LOG2-1:0] PRE_ADDR    = DEPTH_LOG2'(PRETRIG);
    localparam logic [DEPTH_LOG2-1:0] POST_INIT   = DEPTH_LOG2'(DEPTH - 1 - PRETRIG);
    localparam logic [DEPTH_LOG2-1:0] POST_ONE    = DEPTH_LOG2'(1);
    localparam bit                    POST_NONE   = (DEPTH - 1 - PRETRIG) == 0;
    localparam logic [DEPTH_LOG2:0]   LAST_SAMPLE = (DEPTH_LOG2+1)'(DEPTH - 1);
    localparam logic [BIDX_W-1:0]     LAST_BYTE   = BIDX_W'(NBYTES - 1);
    localparam logic [DIV_W-1:0]      DIV_LAST    = DIV_W'(CLKDIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DUMP  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [WIDTH-1:0]      r_rdata;
    logic [WIDTH-1:0]      r_shreg;
    logic [DEPTH_LOG2-1:0] r_waddr;
    logic [DEPTH_LOG2-1:0] r_raddr;
    logic [DEPTH_LOG2-1:0] r_post;
    logic [DEPTH_LOG2:0]   r_fill;
    logic [DEPTH_LOG2:0]   r_scnt;
    logic [BIDX_W-1:0]     r_byte;
    logic [3:0]            r_bit;
    logic [DIV_W-1:0]      r_div;
    logic                  r_sending;
    logic                  r_primed;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_triggered;

    logic w_capture;
    logic w_trig_hit;
    logic w_bit_end;
    logic w_frame_end;
    logic w_sample_end;
    logic w_dump_done;

    assign w_capture    = (r_state == ST_ARMED) || (r_state == ST_POST);
    assign w_trig_hit   = (r_state == ST_ARMED) && trig_in && (r_fill == PRE_FILL);
    assign w_bit_end    = r_sending && (r_div == DIV_LAST);
    assign w_frame_end  = w_bit_end && (r_bit == 4'd9);
    assign w_sample_end = w_frame_end && (r_byte == LAST_BYTE);
    assign w_dump_done  = w_sample_end && (r_scnt == LAST_SAMPLE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (arm) w_next = ST_ARMED;
            ST_ARMED: if (w_trig_hit) w_next = POST_NONE ? ST_DUMP : ST_POST;
            ST_POST:  if (r_post == POST_ONE) w_next = ST_DUMP;
            ST_DUMP:  if (w_dump_done) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
        if (abort) w_next = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != ST_IDLE);
        end
    end

    // Capture RAM: kept free of reset so it maps onto block memory.
    always_ff @(posedge clk) begin
        if (w_capture) r_mem[r_waddr] <= trace_in;
        r_rdata <= r_mem[r_raddr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_waddr     <= '0;
            r_raddr     <= '0;
            r_post      <= '0;
            r_fill      <= '0;
            r_scnt      <= '0;
            r_byte      <= '0;
            r_bit       <= '0;
            r_div       <= '0;
            r_shreg     <= '0;
            r_sending   <= 1'b0;
            r_primed    <= 1'b0;
            r_tx        <= 1'b1;
            r_triggered <= 1'b0;
        end else if (abort) begin
            r_triggered <= 1'b0;
            r_tx        <= 1'b1;
            r_sending   <= 1'b0;
            r_primed    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (arm) begin
                        r_waddr     <= '0;
                        r_fill      <= '0;
                        r_triggered <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    r_waddr <= r_waddr + 1'b1;
                    if (r_fill != PRE_FILL) r_fill <= r_fill + 1'b1;
                    if (w_trig_hit) begin
                        r_raddr     <= r_waddr - PRE_ADDR;
                        r_post      <= POST_INIT;
                        r_triggered <= 1'b1;
                    end
                end
                ST_POST: begin
                    r_waddr <= r_waddr + 1'b1;
                    r_post  <= r_post - 1'b1;
                end
                ST_DUMP: begin
                    // One idle cycle lets r_rdata settle on mem[start]; after that
                    // each sample load advances r_raddr so the next word is ready early.
                    if (!r_sending) begin
                        if (!r_primed) begin
                            r_primed <= 1'b1;
                        end else begin
                            r_shreg   <= r_rdata;
                            r_raddr   <= r_raddr + 1'b1;
                            r_scnt    <= '0;
                            r_byte    <= '0;
                            r_bit     <= '0;
                            r_div     <= '0;
                            r_tx      <= 1'b0;
                            r_sending <= 1'b1;
                        end
                    end else if (w_bit_end) begin
                        r_div <= '0;
                        if (w_frame_end) begin
                            if (w_dump_done) begin
                                r_sending <= 1'b0;
                                r_primed  <= 1'b0;
                                r_tx      <= 1'b1;
                            end else if (w_sample_end) begin
                                r_shreg <= r_rdata;
                                r_raddr <= r_raddr + 1'b1;
                                r_scnt  <= r_scnt + 1'b1;
                                r_byte  <= '0;
                                r_bit   <= '0;
                                r_tx    <= 1'b0;
                            end else begin
                                r_shreg <= r_shreg >> 8;
                                r_byte  <= r_byte + 1'b1;
                                r_bit   <= '0;
                                r_tx    <= 1'b0;
                            end
                        end else begin
                            r_bit <= r_bit + 1'b1;
                            r_tx  <= (r_bit < 4'd8) ? r_shreg[r_bit[2:0]] : 1'b1;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign uart_tx   = r_tx;
    assign busy      = r_busy;
    assign triggered = r_triggered;

endmodule
`default_nettype wire

// File: tb/tb_trace_scope.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_trace_scope
// Purpose  : Randomised scoreboard bench for trace_scope with UART decoder
// Revision : 1.0
// ============================================================================
module tb_trace_scope;

    localparam int WIDTH      = 16;
    localparam int DEPTH_LOG2 = 4;
    localparam int PRETRIG    = 4;
    localparam int CLKDIV     = 4;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int NBYTES     = WIDTH / 8;
    localparam int FRAME      = 10 * CLKDIV;
    localparam int DUMP_CYC   = DEPTH * NBYTES * FRAME;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] trace_in = '0;
    logic             trig_in = 1'b0;
    logic             arm = 1'b0;
    logic             abort = 1'b0;
    logic             uart_tx;
    logic             busy;
    logic             triggered;

    trace_scope #(
        .WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2), .PRETRIG(PRETRIG), .CLKDIV(CLKDIV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .trace_in(trace_in), .trig_in(trig_in),
        .arm(arm), .abort(abort), .uart_tx(uart_tx), .busy(busy), .triggered(triggered)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;
    int epoch = 0;
    int dump_id = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // UART decoder: samples each bit in its middle and pops the expected byte.
    initial begin : monitor
        int st, my_epoch, my_dump, last_start, last_epoch, last_dump;
        logic [7:0] b;
        logic stop_bit;
        last_start = -1; last_epoch = -1; last_dump = -1;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && uart_tx === 1'b0) begin
                st = cyc; my_epoch = epoch; my_dump = dump_id;
                if (my_dump == last_dump && my_epoch == last_epoch)
                    chk("frame_period", st - last_start, FRAME);
                last_start = st; last_epoch = my_epoch; last_dump = my_dump;
                b = '0; stop_bit = 1'b0;
                for (int c = 1; c <= 38; c++) begin
                    @(negedge clk);
                    if (c >= 6 && c <= 34 && (c % 4) == 2) b[(c - 6) / 4] = uart_tx;
                    if (c == 38) stop_bit = uart_tx;
                end
                if (epoch == my_epoch) begin
                    chk("stop_bit", stop_bit, 1);
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL uart_byte: got 0x%02h, expected nothing (queue empty)", b);
                    end else begin
                        chk("uart_byte", b, exp_q.pop_front());
                    end
                end
            end
        end
    end

    // Arms the scope and drives samples until the model says the window is complete.
    // pulse_a/pulse_b: n indices of trigger pulses; rnd: random data and trigger noise.
    task automatic capture(input int pulse_a, input int pulse_b, input bit rnd,
                           input bit arm_in_post, output int t_acc);
        logic [WIDTH-1:0] hist[$];
        logic [WIDTH-1:0] v;
        int n;
        bit done;
        t_acc = -1;
        arm = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
        dump_id++;
        chk("busy_after_arm", busy, 1);
        n = 0; done = 1'b0;
        while (!done) begin
            v = rnd ? WIDTH'($urandom) : WIDTH'(32'h0100 + n);
            trace_in = v;
            hist.push_back(v);
            trig_in = rnd ? ($urandom_range(0, 5) == 0) : (n == pulse_a || n == pulse_b);
            if (t_acc < 0 && trig_in && n >= PRETRIG) t_acc = n;
            arm = arm_in_post && t_acc >= 0 && n == t_acc + 3;
            @(posedge clk); #1;
            chk("busy_capture", busy, 1);
            chk("triggered", triggered, (t_acc >= 0) ? 1 : 0);
            if (t_acc >= 0 && n == t_acc + DEPTH - 1 - PRETRIG) done = 1'b1;
            if (n > 400) begin
                chk("trigger_timeout", 0, 1);
                done = 1'b1;
                t_acc = -1;
            end
            n++;
        end
        trig_in = 1'b0;
        arm = 1'b0;
        if (t_acc >= 0) begin
            for (int s = t_acc - PRETRIG; s < t_acc - PRETRIG + DEPTH; s++)
                for (int k = 0; k < NBYTES; k++)
                    exp_q.push_back(8'(hist[s] >> (8 * k)));
        end
    endtask

    // Runs from DUMP entry until busy drops; optional arm pulse and abort edge index.
    task automatic run_dump(input int arm_at, input int abort_at);
        int k;
        k = 0;
        while (busy === 1'b1 && k < DUMP_CYC + 50) begin
            arm   = (k == arm_at);
            abort = (k == abort_at);
            @(posedge clk); #1;
            k++;
            arm = 1'b0; abort = 1'b0;
            if (arm_at >= 0 && k == arm_at + 1) begin
                chk("arm_in_dump_triggered", triggered, 1);
                chk("arm_in_dump_busy", busy, 1);
            end
            if (abort_at >= 0 && k == abort_at + 1) begin
                chk("abort_uart_tx", uart_tx, 1);
                chk("abort_busy", busy, 0);
                chk("abort_triggered", triggered, 0);
                epoch++;
                chk("bytes_left_at_abort", exp_q.size(), DEPTH * NBYTES - 4);
                exp_q.delete();
            end
        end
        if (abort_at < 0) begin
            n_cmp++;
            if (k < DUMP_CYC || k > DUMP_CYC + 3) begin
                n_fail++;
                $display("FAIL dump_length: busy fell after %0d cycles, expected %0d..%0d",
                         k, DUMP_CYC, DUMP_CYC + 3);
            end
            chk("queue_empty", exp_q.size(), 0);
            chk("idle_uart_tx", uart_tx, 1);
        end
    endtask

    initial begin : stim
        int t;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_uart_tx", uart_tx, 1);
        chk("reset_busy", busy, 0);
        chk("reset_triggered", triggered, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            trig_in = ~trig_in;
            trace_in = WIDTH'($urandom);
            @(posedge clk); #1;
            chk("noarm_uart_tx", uart_tx, 1);
            chk("noarm_busy", busy, 0);
            chk("noarm_triggered", triggered, 0);
        end
        trig_in = 1'b0;

        capture(10, -1, 1'b0, 1'b0, t);          // basic trigger
        run_dump(-1, -1);
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1;
        capture(2, 7, 1'b0, 1'b0, t);            // early pulse ignored
        run_dump(-1, -1);
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1;
        capture(40, -1, 1'b0, 1'b0, t);          // ring wrap
        run_dump(-1, -1);
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1;
        capture(10, -1, 1'b0, 1'b1, t);          // arm in POST, arm in DUMP, abort in frame 5
        run_dump(50, 181);
        repeat (60) @(posedge clk);
        #1;
        chk("post_abort_uart_tx", uart_tx, 1);
        chk("post_abort_busy", busy, 0);
        capture(10, -1, 1'b0, 1'b0, t);          // recovery after abort
        run_dump(-1, -1);
        for (int r = 0; r < 2; r++) begin
            repeat ($urandom_range(1, 6)) @(posedge clk);
            #1;
            capture(-1, -1, 1'b1, 1'b0, t);      // random data and trigger noise
            run_dump(-1, -1);
        end
        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
